// File: rtl/spi_master_controller.sv
// SPI initiator: LSB-first 1..32 bit transfers in all CPOL/CPHA modes with baud divider.
// Define SPI_MASTER_DELAY_EN to honour ct2_delay/t2c_delay; otherwise they are ignored.
module spi_master_controller #(
    parameter int unsigned NO_OF_SLAVES = 1,
    parameter int unsigned DIV_WIDTH    = 8
) (
    input  logic                            pclk,
    input  logic                            areset,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    input  logic                            cpol,
    input  logic                            cpha,
    input  logic [5:0]                      char_len,
    input  logic [DIV_WIDTH-1:0]            baud_div,
    input  logic [DIV_WIDTH-1:0]            ct2_delay,
    input  logic [DIV_WIDTH-1:0]            t2c_delay,
    input  logic [$clog2(NO_OF_SLAVES):0]   cs_sel,
    input  logic [31:0]                     tx_data,
    output logic [31:0]                     rx_data,
    output logic                            sclk,
    output logic [NO_OF_SLAVES-1:0]         cs,
    output logic                            mosi0,
    input  logic                            miso0
);

    localparam int unsigned SEL_W = $clog2(NO_OF_SLAVES) + 1;
    localparam int unsigned CNT_W = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [6:0]              edge_q;
    logic [5:0]              n_q;
    logic                    cpha_q;
    logic [DIV_WIDTH-1:0]    bd_q;
    logic [DIV_WIDTH-1:0]    t2c_q;
    logic [31:0]             tx_q;
    logic [31:0]             rx_sh_q;
    logic [31:0]             rx_q;
    logic                    sclk_q;
    logic [NO_OF_SLAVES-1:0] cs_q;
    logic                    mosi_q;
    logic                    busy_q;
    logic                    done_q;

    logic [DIV_WIDTH-1:0]    ct2_eff_c;
    logic [DIV_WIDTH-1:0]    t2c_eff_c;
    logic [5:0]              n_eff_c;
    logic                    edge_now_c;
    logic                    leading_c;
    logic                    last_edge_c;
    logic                    more_bits_c;
    logic [4:0]              bit_idx_c;

`ifdef SPI_MASTER_DELAY_EN
    assign ct2_eff_c = ct2_delay;
    assign t2c_eff_c = t2c_delay;
`else
    logic unused_delay_c;
    assign unused_delay_c = ^{ct2_delay, t2c_delay};
    assign ct2_eff_c      = '0;
    assign t2c_eff_c      = '0;
`endif

    // 0 or out-of-range lengths mean a full 32-bit word
    assign n_eff_c     = (char_len == 6'd0 || char_len > 6'd32) ? 6'd32 : char_len;
    assign edge_now_c  = (state_q == SETUP || state_q == SHIFT) && (cnt_q == '0);
    assign leading_c   = ~edge_q[0];
    assign bit_idx_c   = edge_q[5:1];
    assign last_edge_c = (edge_q == 7'({n_q, 1'b0} - 7'd1));
    assign more_bits_c = (6'(bit_idx_c) + 6'd1) < n_q;

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            edge_q  <= '0;
            n_q     <= 6'd32;
            cpha_q  <= 1'b0;
            bd_q    <= '0;
            t2c_q   <= '0;
            tx_q    <= '0;
            rx_sh_q <= '0;
            rx_q    <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= '1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    sclk_q <= cpol;
                    if (start && (cs_sel < SEL_W'(NO_OF_SLAVES))) begin
                        for (int unsigned i = 0; i < NO_OF_SLAVES; i++) begin
                            cs_q[i] <= (SEL_W'(i) != cs_sel);
                        end
                        n_q     <= n_eff_c;
                        cpha_q  <= cpha;
                        bd_q    <= baud_div;
                        t2c_q   <= t2c_eff_c;
                        tx_q    <= tx_data;
                        rx_sh_q <= '0;
                        mosi_q  <= tx_data[0];
                        busy_q  <= 1'b1;
                        edge_q  <= '0;
                        cnt_q   <= CNT_W'(ct2_eff_c) + CNT_W'(baud_div);
                        state_q <= SETUP;
                    end
                end
                SETUP, SHIFT: begin
                    if (edge_now_c) begin
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 7'd1;
                        // sample on the phase-selected edge, launch next bit on the other
                        if (leading_c == ~cpha_q) begin
                            rx_sh_q[bit_idx_c] <= miso0;
                        end else if (!cpha_q) begin
                            if (more_bits_c) begin
                                mosi_q <= tx_q[bit_idx_c + 5'd1];
                            end
                        end else begin
                            mosi_q <= tx_q[bit_idx_c];
                        end
                        if (last_edge_c) begin
                            cnt_q   <= CNT_W'(t2c_q) + CNT_W'(bd_q);
                            state_q <= HOLD;
                        end else begin
                            cnt_q   <= CNT_W'(bd_q);
                            state_q <= SHIFT;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        cs_q    <= '1;
                        rx_q    <= rx_sh_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_q;
    assign sclk    = sclk_q;
    assign cs      = cs_q;
    assign mosi0   = mosi_q;

endmodule

// File: tb/tb_spi_master_controller.sv
// Directed self-checking bench for spi_master_controller with a behavioural SPI slave.
module tb_spi_master_controller;

    logic        pclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic [5:0]  char_len = 6'd8;
    logic [7:0]  baud_div = 8'd0, ct2_delay = 8'd0, t2c_delay = 8'd0;
    logic [0:0]  cs_sel = 1'b0;
    logic [31:0] tx_data = 32'd0;
    logic [31:0] rx_data;
    logic        sclk, mosi0;
    logic        miso0 = 1'b0;
    logic [0:0]  cs;

    spi_master_controller #(.NO_OF_SLAVES(1), .DIV_WIDTH(8)) dut (
        .pclk(pclk), .areset(areset), .start(start), .busy(busy), .done(done),
        .cpol(cpol), .cpha(cpha), .char_len(char_len), .baud_div(baud_div),
        .ct2_delay(ct2_delay), .t2c_delay(t2c_delay), .cs_sel(cs_sel),
        .tx_data(tx_data), .rx_data(rx_data), .sclk(sclk), .cs(cs),
        .mosi0(mosi0), .miso0(miso0)
    );

    always #5 pclk = ~pclk;

    int total = 0;
    int bad   = 0;

    int          r_edges, r_first, r_last, r_rise, r_dcount;
    logic [31:0] r_mos;
    logic        r_busy0, r_cs0, r_mosi_t0, r_sclk_pre, r_sclk_post, r_busy_rise;
    logic        r_done_after, r_timeout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Run one transfer; the bench acts as slave and records timing and the mosi word.
    task automatic xfer(input logic pol, input logic ph, input logic [5:0] len,
                        input logic [7:0] bd, input logic [7:0] c2, input logic [7:0] t2,
                        input logic [31:0] tx, input logic [31:0] pat, input bit loopb,
                        input int abort_at, input int restart_at);
        int   e;
        int   bidx;
        bit   lead;
        logic ps, pm;
        step();
        cpol = pol; cpha = ph; char_len = len; baud_div = bd;
        ct2_delay = c2; t2c_delay = t2; tx_data = tx; cs_sel = 1'b0;
        step();
        r_sclk_pre = sclk;
        start = 1'b1;
        step();
        start = 1'b0;
        r_busy0 = busy; r_cs0 = cs[0]; r_mosi_t0 = mosi0;
        // disturb latched inputs; the transfer must not notice
        tx_data = ~tx; char_len = 6'd3; baud_div = bd + 8'd1; cpha = ~ph;
        miso0 = loopb ? mosi0 : pat[0];
        ps = sclk; pm = mosi0; e = 0;
        r_mos = '0; r_dcount = 0; r_first = -1; r_last = -1; r_rise = -1;
        r_timeout = 1'b1; r_edges = 0;
        for (int t = 1; t < 3000; t++) begin
            step();
            start = (t == restart_at);
            if (done) r_dcount++;
            if (sclk !== ps) begin
                e++;
                if (r_first < 0) r_first = t;
                r_last = t;
                lead = (e % 2) == 1;
                bidx = (e - 1) / 2;
                if ((lead != ph) && bidx < 32) r_mos[bidx] = pm;
                if (!loopb) begin
                    if (!ph && !lead && bidx + 1 < 32) miso0 = pat[bidx + 1];
                    if (ph && lead && bidx < 32) miso0 = pat[bidx];
                end
                if (e == abort_at) begin
                    r_edges = e;
                    r_timeout = 1'b0;
                    areset = 1'b1;
                    #1;
                    return;
                end
            end
            if (loopb) miso0 = mosi0;
            ps = sclk; pm = mosi0;
            if (cs[0]) begin
                r_rise = t; r_busy_rise = busy; r_sclk_post = sclk; r_timeout = 1'b0;
                break;
            end
        end
        r_edges = e;
        start = 1'b0;
        cpha = ph;
        step();
        r_done_after = done;
    endtask

    initial begin
        step();
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_mosi", 32'(mosi0), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx", rx_data, 32'd0);
        areset = 1'b0;
        step();

        // mode 0, 8 bits, baud_div 1
        xfer(1'b0, 1'b0, 6'd8, 8'd1, 8'd0, 8'd0, 32'h0000_00A5, 32'h0000_003C, 1'b0, 0, 0);
        chk("m0_timeout", 32'(r_timeout), 32'd0);
        chk("m0_busy_rise_cycle", 32'(r_busy0), 32'd1);
        chk("m0_cs_fall", 32'(r_cs0), 32'd0);
        chk("m0_edges", 32'(r_edges), 32'd16);
        chk("m0_first_edge", 32'(r_first), 32'd2);
        chk("m0_cs_rise", 32'(r_rise), 32'd34);
        chk("m0_mosi_word", r_mos, 32'h0000_00A5);
        chk("m0_rx", rx_data, 32'h0000_003C);
        chk("m0_done_cnt", 32'(r_dcount), 32'd1);
        chk("m0_done_after", 32'(r_done_after), 32'd0);
        chk("m0_busy_at_rise", 32'(r_busy_rise), 32'd0);

        // mode 3, 32 bits, loopback
        xfer(1'b1, 1'b1, 6'd32, 8'd0, 8'd0, 8'd0, 32'hDEAD_BEEF, 32'd0, 1'b1, 0, 0);
        chk("m3_sclk_pre", 32'(r_sclk_pre), 32'd1);
        chk("m3_sclk_post", 32'(r_sclk_post), 32'd1);
        chk("m3_edges", 32'(r_edges), 32'd64);
        chk("m3_cs_rise", 32'(r_rise), 32'd65);
        chk("m3_mosi_word", r_mos, 32'hDEAD_BEEF);
        chk("m3_rx", rx_data, 32'hDEAD_BEEF);

        // cs timing delays, 4 bits; upper rx bits must stay zero
        xfer(1'b0, 1'b0, 6'd4, 8'd0, 8'd3, 8'd5, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0, 0, 0);
        chk("dly_edges", 32'(r_edges), 32'd8);
`ifdef SPI_MASTER_DELAY_EN
        chk("dly_first_edge", 32'(r_first), 32'd4);
        chk("dly_last_to_rise", 32'(r_rise - r_last), 32'd6);
`else
        chk("dly_first_edge", 32'(r_first), 32'd1);
        chk("dly_last_to_rise", 32'(r_rise - r_last), 32'd1);
`endif
        chk("dly_rx", rx_data, 32'h0000_000F);
        chk("dly_mosi_word", r_mos, 32'h0000_0009);

        // char_len 0 means 32 bits; start pulsed while busy is ignored
        xfer(1'b0, 1'b1, 6'd0, 8'd0, 8'd0, 8'd0, 32'h1234_5678, 32'hCAFE_F00D, 1'b0, 0, 5);
        chk("len0_edges", 32'(r_edges), 32'd64);
        chk("len0_cs_rise", 32'(r_rise), 32'd65);
        chk("len0_rx", rx_data, 32'hCAFE_F00D);
        chk("len0_mosi_word", r_mos, 32'h1234_5678);
        step();
        chk("len0_no_restart_busy", 32'(busy), 32'd0);
        chk("len0_no_restart_cs", 32'(cs), 32'd1);

        // invalid cs_sel
        cs_sel = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("badsel_busy", 32'(busy), 32'd0);
        chk("badsel_cs", 32'(cs), 32'd1);
        step();
        chk("badsel_busy2", 32'(busy), 32'd0);
        chk("badsel_done", 32'(done), 32'd0);
        cs_sel = 1'b0;

        // reset on edge 5 of an 8-bit transfer
        xfer(1'b0, 1'b0, 6'd8, 8'd1, 8'd0, 8'd0, 32'h0000_00FF, 32'h0000_0055, 1'b0, 5, 0);
        chk("abort_edge", 32'(r_edges), 32'd5);
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        areset = 1'b0;
        step();
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_rx_cleared", rx_data, 32'd0);

        // mode 1 after reset
        xfer(1'b0, 1'b1, 6'd8, 8'd1, 8'd0, 8'd0, 32'h0000_0081, 32'h0000_005A, 1'b0, 0, 0);
        chk("m1_cs_rise", 32'(r_rise), 32'd34);
        chk("m1_mosi_word", r_mos, 32'h0000_0081);
        chk("m1_rx", rx_data, 32'h0000_005A);
        chk("m1_done_cnt", 32'(r_dcount), 32'd1);

        // mode 2, baud_div 2
        xfer(1'b1, 1'b0, 6'd8, 8'd2, 8'd0, 8'd0, 32'h0000_0001, 32'h0000_0096, 1'b0, 0, 0);
        chk("m2_mosi_first", 32'(r_mosi_t0), 32'd1);
        chk("m2_sclk_pre", 32'(r_sclk_pre), 32'd1);
        chk("m2_cs_rise", 32'(r_rise), 32'd51);
        chk("m2_mosi_word", r_mos, 32'h0000_0001);
        chk("m2_rx", rx_data, 32'h0000_0096);
        chk("m2_timeout", 32'(r_timeout), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
